// File: rtl/dma_engine.sv
// dma_engine: memory-to-memory copy and destination pattern self-test engine fed by the APB config slave
module dma_engine #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MODE           = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [REG_DATA_WIDTH-1:0]   in_src_addr,
    input  logic [REG_DATA_WIDTH-1:0]   in_dest_addr,
    input  logic [REG_DATA_WIDTH-1:0]   in_transfer_size,
    input  logic [MODE-1:0]             in_mode,
    input  logic                        in_mem_sel,
    output logic                        out_status_update,
    output logic                        out_led_update,
    output logic [1:0]                  out_led,
    output logic                        out_mem0_en,
    output logic                        out_mem0_we,
    output logic [MEM_ADDR_WIDTH-3:0]   out_mem0_addr,
    output logic [MEM_DATA_WIDTH-1:0]   out_mem0_wdata,
    input  logic [MEM_DATA_WIDTH-1:0]   in_mem0_rdata,
    output logic                        out_mem1_en,
    output logic                        out_mem1_we,
    output logic [MEM_ADDR_WIDTH-3:0]   out_mem1_addr,
    output logic [MEM_DATA_WIDTH-1:0]   out_mem1_wdata,
    input  logic [MEM_DATA_WIDTH-1:0]   in_mem1_rdata
);
    localparam int AW = MEM_ADDR_WIDTH - 2;

    typedef enum logic [2:0] {IDLE, RD, WR, TW, TR, TC, DONE, HOLD} state_t;

    state_t                    state, state_nx;
    logic [AW-1:0]             src_base, dst_base, src_addr, dst_addr;
    logic [REG_DATA_WIDTH-1:0] cnt, idx;
    logic                      sel, err, last, src_en, dst_en, dst_we;
    logic [MEM_DATA_WIDTH-1:0] src_rdata, dst_rdata, dst_wdata, pat;
    logic                      unused;

    // only the in-memory word-index bits of the byte addresses matter
    assign unused    = ^{in_src_addr[REG_DATA_WIDTH-1:MEM_ADDR_WIDTH], in_src_addr[1:0],
                         in_dest_addr[REG_DATA_WIDTH-1:MEM_ADDR_WIDTH], in_dest_addr[1:0]};
    assign last      = idx == cnt - REG_DATA_WIDTH'(1);
    assign pat       = MEM_DATA_WIDTH'({16'hA5A5, idx[15:0]});
    assign src_rdata = sel ? in_mem1_rdata : in_mem0_rdata;
    assign dst_rdata = sel ? in_mem0_rdata : in_mem1_rdata;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state logic; HOLD waits for mode to drop so a stale mode cannot retrigger
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_mode != '0)
                      state_nx = (in_mode == '1 || in_transfer_size == '0) ? DONE :
                                 (in_mode == MODE'(1)) ? RD : TW;
            RD:   state_nx = WR;
            WR:   state_nx = last ? DONE : RD;
            TW:   state_nx = last ? TR : TW;
            TR:   state_nx = TC;
            TC:   state_nx = last ? DONE : TR;
            DONE: state_nx = HOLD;
            HOLD: state_nx = (in_mode == '0) ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // transfer context: latched at start, word offset advances per word, sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_base <= '0;
            dst_base <= '0;
            cnt      <= '0;
            idx      <= '0;
            sel      <= 1'b0;
            err      <= 1'b0;
        end else if (state == IDLE) begin
            if (in_mode != '0) begin
                src_base <= in_src_addr[MEM_ADDR_WIDTH-1:2];
                dst_base <= in_dest_addr[MEM_ADDR_WIDTH-1:2];
                cnt      <= in_transfer_size;
                idx      <= '0;
                sel      <= in_mem_sel;
                err      <= in_mode == '1;
            end
        end else if (state == WR || state == TW) begin
            idx <= (state == TW && last) ? '0 : idx + REG_DATA_WIDTH'(1);
        end else if (state == TC) begin
            err <= err | (dst_rdata != pat);
            idx <= idx + REG_DATA_WIDTH'(1);
        end
    end

    // outputs: logical src/dst ports steered onto the physical memories by the latched select
    always_comb begin
        src_en            = state == RD;
        dst_en            = state == WR || state == TW || state == TR;
        dst_we            = state == WR || state == TW;
        src_addr          = src_en ? src_base + idx[AW-1:0] : '0;
        dst_addr          = dst_en ? dst_base + idx[AW-1:0] : '0;
        dst_wdata         = (state == WR) ? src_rdata : (state == TW) ? pat : '0;
        out_status_update = state == DONE;
        out_led_update    = state == DONE;
        out_led           = (state != DONE) ? 2'b00 : err ? 2'b10 : 2'b01;
        out_mem0_en       = sel ? dst_en : src_en;
        out_mem0_we       = sel ? dst_we : 1'b0;
        out_mem0_addr     = sel ? dst_addr : src_addr;
        out_mem0_wdata    = sel ? dst_wdata : '0;
        out_mem1_en       = sel ? src_en : dst_en;
        out_mem1_we       = sel ? 1'b0 : dst_we;
        out_mem1_addr     = sel ? src_addr : dst_addr;
        out_mem1_wdata    = sel ? '0 : dst_wdata;
    end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed self-checking bench for dma_engine with two behavioural memories
module tb_dma_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_src_addr = '0, in_dest_addr = '0, in_transfer_size = '0;
    logic [1:0]  in_mode = '0;
    logic        in_mem_sel = 1'b0;
    logic        out_status_update, out_led_update;
    logic [1:0]  out_led;
    logic        out_mem0_en, out_mem0_we, out_mem1_en, out_mem1_we;
    logic [13:0] out_mem0_addr, out_mem1_addr;
    logic [31:0] out_mem0_wdata, out_mem1_wdata, in_mem0_rdata, in_mem1_rdata;

    logic [31:0] mem0 [0:16383];
    logic [31:0] mem1 [0:16383];
    int          wr0 = 0, wr1 = 0, en_cnt = 0, stat_cnt = 0;
    logic [13:0] log1 [$];
    logic [13:0] log0 [$];
    logic        pl_en = 1'b0, pl_sel = 1'b0, corrupt = 1'b0;
    logic [13:0] pl_addr = '0, corrupt_addr = '0;
    logic [31:0] pl_data = '0;

    int tests = 0, failed = 0;

    dma_engine dut (
        .clk(clk), .reset(reset),
        .in_src_addr(in_src_addr), .in_dest_addr(in_dest_addr),
        .in_transfer_size(in_transfer_size), .in_mode(in_mode), .in_mem_sel(in_mem_sel),
        .out_status_update(out_status_update), .out_led_update(out_led_update), .out_led(out_led),
        .out_mem0_en(out_mem0_en), .out_mem0_we(out_mem0_we), .out_mem0_addr(out_mem0_addr),
        .out_mem0_wdata(out_mem0_wdata), .in_mem0_rdata(in_mem0_rdata),
        .out_mem1_en(out_mem1_en), .out_mem1_we(out_mem1_we), .out_mem1_addr(out_mem1_addr),
        .out_mem1_wdata(out_mem1_wdata), .in_mem1_rdata(in_mem1_rdata)
    );

    always #5 clk = ~clk;

    // synchronous memories with 1-cycle read latency, bench preload port and optional read corruption on mem1
    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem0[pl_addr] <= pl_data;
        if (pl_en && pl_sel)  mem1[pl_addr] <= pl_data;
        if (out_mem0_en || out_mem1_en) en_cnt <= en_cnt + 1;
        if (out_status_update) stat_cnt <= stat_cnt + 1;
        if (out_mem0_en && out_mem0_we) begin
            mem0[out_mem0_addr] <= out_mem0_wdata;
            wr0 <= wr0 + 1;
            log0.push_back(out_mem0_addr);
        end else if (out_mem0_en) in_mem0_rdata <= mem0[out_mem0_addr];
        if (out_mem1_en && out_mem1_we) begin
            mem1[out_mem1_addr] <= out_mem1_wdata;
            wr1 <= wr1 + 1;
            log1.push_back(out_mem1_addr);
        end else if (out_mem1_en)
            in_mem1_rdata <= mem1[out_mem1_addr] ^ ((corrupt && out_mem1_addr == corrupt_addr) ? 32'h1 : 32'h0);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic s, input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_sel = s; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // start a transfer, count cycles to the done pulse, capture led/led_update and the next-cycle pulse level
    task automatic run(input logic [1:0] m, input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] size, input logic s, input logic clear,
                       output int cyc, output logic [1:0] led, output logic lu, output logic after);
        @(negedge clk);
        in_mode = m; in_src_addr = src; in_dest_addr = dst; in_transfer_size = size; in_mem_sel = s;
        cyc = -1; led = 2'b11; lu = 1'b0; after = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (out_status_update) begin
                cyc = k; led = out_led; lu = out_led_update;
                break;
            end
        end
        if (clear) in_mode = 2'b00;
        @(negedge clk);
        after = out_status_update;
        @(negedge clk);
    endtask

    int         cyc, w0, w1, e0, s0, n1;
    logic [1:0] led;
    logic       lu, after;

    initial begin
        #1;
        check("reset_outputs", {out_status_update, out_led_update, out_led, out_mem0_en, out_mem1_en}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // 1: normal copy mem0[0..3] -> mem1[4..7]
        for (int k = 0; k < 4; k++) preload(1'b0, 14'(k), 32'(k + 1));
        w0 = wr0;
        run(2'b01, 32'h0001_0000, 32'h0002_0010, 32'd4, 1'b0, 1'b1, cyc, led, lu, after);
        check("t1_cycle", cyc, 9);
        check("t1_led", led, 2'b01);
        check("t1_led_update", lu, 1'b1);
        check("t1_pulse_width", after, 1'b0);
        check("t1_data", {mem1[4], mem1[5], mem1[6], mem1[7]}, {32'd1, 32'd2, 32'd3, 32'd4});
        check("t1_src_untouched", wr0 - w0, 0);

        // 2: swapped routing, mem1[0..3] -> mem0[4..7]
        for (int k = 0; k < 4; k++) preload(1'b1, 14'(k), 32'(k + 11));
        w1 = wr1;
        run(2'b01, 32'h0001_0000, 32'h0002_0010, 32'd4, 1'b1, 1'b1, cyc, led, lu, after);
        check("t2_cycle", cyc, 9);
        check("t2_data", {mem0[4], mem0[5], mem0[6], mem0[7]}, {32'd11, 32'd12, 32'd13, 32'd14});
        check("t2_mem1_not_written", wr1 - w1, 0);

        // 3: test mode, 8 words at dst idx 0, then repeat with word 3 read back corrupted
        run(2'b10, 32'h0, 32'h0, 32'd8, 1'b0, 1'b1, cyc, led, lu, after);
        check("t3_cycle", cyc, 25);
        check("t3_led_pass", led, 2'b01);
        for (int k = 0; k < 8; k++) check("t3_pattern", mem1[k], 32'hA5A5_0000 + 32'(k));
        corrupt_addr = 14'd3; corrupt = 1'b1;
        run(2'b10, 32'h0, 32'h0, 32'd8, 1'b0, 1'b1, cyc, led, lu, after);
        corrupt = 1'b0;
        check("t3_corrupt_cycle", cyc, 25);
        check("t3_led_fail", led, 2'b10);

        // 4: zero size and illegal mode finish immediately without memory access
        e0 = en_cnt;
        run(2'b01, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, cyc, led, lu, after);
        check("t4_size0_cycle", cyc, 1);
        check("t4_size0_led", led, 2'b01);
        run(2'b11, 32'h0, 32'h0, 32'd5, 1'b0, 1'b1, cyc, led, lu, after);
        check("t4_mode3_cycle", cyc, 1);
        check("t4_mode3_led", led, 2'b10);
        check("t4_no_enable", en_cnt - e0, 0);

        // 5: destination index wraps; mode left at 01 must not retrigger
        for (int k = 0; k < 4; k++) preload(1'b0, 14'(k + 8), 32'h100 + 32'(k));
        n1 = log1.size();
        run(2'b01, 32'h0000_0020, 32'h0000_FFF8, 32'd4, 1'b0, 1'b0, cyc, led, lu, after);
        check("t5_cycle", cyc, 9);
        check("t5_addrs", {log1[n1], log1[n1 + 1], log1[n1 + 2], log1[n1 + 3]},
              {14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001});
        check("t5_data", {mem1[16382], mem1[16383], mem1[0], mem1[1]},
              {32'h100, 32'h101, 32'h102, 32'h103});
        s0 = stat_cnt; e0 = en_cnt;
        repeat (20) @(negedge clk);
        check("t5_hold_no_pulse", stat_cnt - s0, 0);
        check("t5_hold_no_access", en_cnt - e0, 0);
        in_mode = 2'b00;
        repeat (2) @(negedge clk);

        // 6: reset during the 3rd write of an 8-word copy
        for (int k = 0; k < 8; k++) preload(1'b0, 14'(k), 32'h200 + 32'(k));
        in_mode = 2'b01; in_src_addr = 32'h0; in_dest_addr = 32'h40; in_transfer_size = 32'd8; in_mem_sel = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_in_third_write", {out_mem1_en, out_mem1_we, out_mem1_addr}, {1'b1, 1'b1, 14'd18});
        reset = 1'b0;
        #1;
        check("t6_reset_outputs", {out_status_update, out_led_update, out_led, out_mem0_en, out_mem0_we,
              out_mem0_addr, out_mem0_wdata, out_mem1_en, out_mem1_we, out_mem1_addr, out_mem1_wdata}, '0);
        in_mode = 2'b00;
        s0 = stat_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_pulse_after_reset", stat_cnt - s0, 0);
        run(2'b01, 32'h0, 32'h40, 32'd8, 1'b0, 1'b1, cyc, led, lu, after);
        check("t6_restart_cycle", cyc, 17);
        check("t6_restart_led", led, 2'b01);
        check("t6_restart_data", {mem1[16], mem1[23]}, {32'h200, 32'h207});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
